// File: rtl/gf_digit_mul_seq.sv
// -----------------------------------------------------------------------------
// gf_digit_mul_seq
//
// Digit-serial GF(2^m) / integer arithmetic unit. One command at a time is
// captured in IDLE, multiplied DIGIT_WIDTH bits of b per cycle (MSB first),
// optionally reduced DIGIT_WIDTH product positions per cycle by the runtime
// polynomial, and presented in DONE until the consumer accepts it.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  command handshake (ready only in IDLE)
//   op              00 GF add, 01 GF mul, 10 GF square, 11 integer mul
//   polyn_grade     field degree m (legal 2..DATA_WIDTH for GF ops)
//   polyn_red       reduction polynomial, bit m set
//   a, b            operands (masked to m bits for GF ops at capture)
//   out_valid/ready result handshake, result held until accepted
//   out             reduced GF result or integer low word
//   mult_out        unreduced product (0 for add / error)
//   err             illegal degree for the captured GF command
//   busy            not in IDLE
// -----------------------------------------------------------------------------
module gf_digit_mul_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    op,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH:0]           polyn_red,
  input  logic [DATA_WIDTH-1:0]         a,
  input  logic [DATA_WIDTH-1:0]         b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out,
  output logic [2*DATA_WIDTH-1:0]       mult_out,
  output logic                          err,
  output logic                          busy
);

  localparam int MW    = $clog2(DATA_WIDTH) + 1;              // degree field width
  localparam int PW    = 2 * DATA_WIDTH;                      // product width
  localparam int N_MUL = (DATA_WIDTH + DIGIT_WIDTH - 1) / DIGIT_WIDTH;
  localparam int NB    = N_MUL * DIGIT_WIDTH;                 // b padded to whole digits
  localparam int CW    = $clog2(N_MUL + 1);
  localparam int KW    = $clog2(PW);                          // product bit position

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SQR  = 2'b10;
  localparam logic [1:0] OP_IMUL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_MUL,
    S_RED,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [MW-1:0]           m_q, m_d;
  logic [DATA_WIDTH:0]     poly_q, poly_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [NB-1:0]           b_q, b_d;      // shifted left one bit per processed b bit
  logic [PW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [KW-1:0]           k_q, k_d;      // highest product position still to reduce
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [PW-1:0]           mult_q, mult_d;
  logic                    err_q, err_d;

  // Low-m-bit mask; degrees at or above the operand width keep every bit.
  function automatic logic [DATA_WIDTH-1:0] grade_mask(input logic [MW-1:0] m);
    if (m >= MW'(DATA_WIDTH)) begin
      return '1;
    end
    return (DATA_WIDTH'(1) << m) - DATA_WIDTH'(1);
  endfunction

  logic m_legal;
  assign m_legal = (polyn_grade >= MW'(2)) && (polyn_grade <= MW'(DATA_WIDTH));

  always_comb begin
    logic                  is_gf;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] a_m;
    logic [DATA_WIDTH-1:0] b_m;
    logic [PW-1:0]         acc_v;
    logic [NB-1:0]         b_v;
    logic [KW-1:0]         pos;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case statement can leave a value unassigned (no latch).
    state_d = state_q;
    op_d    = op_q;
    m_d     = m_q;
    poly_d  = poly_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    out_d   = out_q;
    mult_d  = mult_q;
    err_d   = err_q;
    is_gf   = 1'b0;
    mask    = '0;
    a_m     = '0;
    b_m     = '0;
    acc_v   = acc_q;
    b_v     = b_q;
    pos     = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          is_gf  = (op != OP_IMUL);
          mask   = grade_mask(polyn_grade);
          a_m    = is_gf ? (a & mask) : a;
          b_m    = is_gf ? (b & mask) : b;
          op_d   = op;
          m_d    = polyn_grade;
          poly_d = polyn_red;
          a_d    = a_m;
          b_d    = NB'((op == OP_SQR) ? a_m : b_m);
          acc_d  = '0;
          cnt_d  = '0;
          k_d    = '0;
          err_d  = 1'b0;
          if (is_gf && !m_legal) begin
            err_d   = 1'b1;
            out_d   = '0;
            mult_d  = '0;
            state_d = S_DONE;
          end else if (op == OP_ADD) begin
            state_d = S_ADD;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_ADD: begin
        out_d   = a_q ^ b_q[DATA_WIDTH-1:0];
        mult_d  = '0;
        state_d = S_DONE;
      end

      S_MUL: begin
        // NOTE: acc_v/b_v are blocking temporaries chained through the unrolled
        // digit loop; only the final values reach the registers via _d.
        for (int j = 0; j < DIGIT_WIDTH; j++) begin
          acc_v = acc_v << 1;
          if (b_v[NB-1]) begin
            acc_v = (op_q == OP_IMUL) ? (acc_v + PW'(a_q)) : (acc_v ^ PW'(a_q));
          end
          b_v = b_v << 1;
        end
        acc_d = acc_v;
        b_d   = b_v;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N_MUL - 1)) begin
          mult_d = acc_v;
          if (op_q == OP_IMUL) begin
            out_d   = acc_v[DATA_WIDTH-1:0];
            state_d = S_DONE;
          end else begin
            k_d     = (KW'(m_q) << 1) - KW'(2);
            state_d = S_RED;
          end
        end
      end

      S_RED: begin
        // Clear positions k_q, k_q-1, ... but never below m: those bits are the
        // remainder and must survive into the result.
        for (int j = 0; j < DIGIT_WIDTH; j++) begin
          if (k_q >= KW'(m_q) + KW'(j)) begin
            pos = k_q - KW'(j);
            if (acc_v[pos]) begin
              acc_v = acc_v ^ (PW'(poly_q) << (pos - KW'(m_q)));
            end
          end
        end
        acc_d = acc_v;
        k_d   = k_q - KW'(DIGIT_WIDTH);
        if ((k_q - KW'(m_q)) < KW'(DIGIT_WIDTH)) begin
          out_d   = acc_v[DATA_WIDTH-1:0] & grade_mask(m_q);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      m_q     <= '0;
      poly_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      out_q   <= '0;
      mult_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      m_q     <= m_d;
      poly_q  <= poly_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      out_q   <= out_d;
      mult_q  <= mult_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign mult_out  = mult_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gf_digit_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_gf_digit_mul_seq
//
// Bench for gf_digit_mul_seq at DATA_WIDTH=8, DIGIT_WIDTH=2: a table of known
// vectors, hand sequences for output hold and mid-operation reset, and random
// commands compared against a bit-level polynomial arithmetic model.
// -----------------------------------------------------------------------------
module tb_gf_digit_mul_seq;

  localparam int W     = 8;
  localparam int D     = 2;
  localparam int MW    = $clog2(W) + 1;
  localparam int N_MUL = (W + D - 1) / D;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [MW-1:0]    polyn_grade;
  logic [W:0]       polyn_red;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic [2*W-1:0]   mult_out;
  logic             err;
  logic             busy;

  int total = 0;
  int bad   = 0;

  gf_digit_mul_seq #(.DATA_WIDTH(W), .DIGIT_WIDTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .polyn_grade(polyn_grade),
    .polyn_red  (polyn_red),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .mult_out   (mult_out),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]     op;
    int             m;
    logic [W:0]     poly;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   e_out;
    logic [2*W-1:0] e_mult;
    logic           e_err;
    int             e_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p = '0;
    for (int i = 0; i < W; i++) begin
      if (y[i]) p = p ^ ((2*W)'(x) << i);
    end
    return p;
  endfunction

  function automatic logic [2*W-1:0] poly_mod(input logic [2*W-1:0] p, input int m,
                                              input logic [W:0] poly);
    for (int k = 2*W - 1; k >= m; k--) begin
      if (p[k]) p = p ^ ((2*W)'(poly) << (k - m));
    end
    return p;
  endfunction

  task automatic model(input logic [1:0] op_v, input int m_v, input logic [W:0] poly_v,
                       input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       output logic [W-1:0] e_out, output logic [2*W-1:0] e_mult,
                       output logic e_err, output int e_lat);
    logic [W-1:0]   am;
    logic [W-1:0]   bm;
    logic [2*W-1:0] p;
    int             msk;
    e_err = 1'b0;
    if (op_v == 2'b11) begin
      p      = (2*W)'(a_v) * (2*W)'(b_v);
      e_mult = p;
      e_out  = p[W-1:0];
      e_lat  = N_MUL + 1;
    end else if (m_v < 2 || m_v > W) begin
      e_err  = 1'b1;
      e_out  = '0;
      e_mult = '0;
      e_lat  = 1;
    end else begin
      msk = (1 << m_v) - 1;
      am  = a_v & W'(msk);
      bm  = b_v & W'(msk);
      if (op_v == 2'b00) begin
        e_out  = am ^ bm;
        e_mult = '0;
        e_lat  = 2;
      end else begin
        p      = clmul(am, (op_v == 2'b10) ? am : bm);
        e_mult = p;
        e_out  = W'(poly_mod(p, m_v, poly_v));
        e_lat  = N_MUL + (m_v - 1 + D - 1) / D + 1;
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_after_hs", in_ready, 1'b1);
  endtask

  task automatic issue(input logic [1:0] op_v, input int m_v, input logic [W:0] poly_v,
                       input logic [W-1:0] a_v, input logic [W-1:0] b_v, input bit hold,
                       output int lat, output logic [W-1:0] o,
                       output logic [2*W-1:0] mo, output logic e);
    @(negedge clk);
    op          = op_v;
    polyn_grade = MW'(m_v);
    polyn_red   = poly_v;
    a           = a_v;
    b           = b_v;
    in_valid    = 1'b1;
    check("in_ready_at_issue", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    // Scramble operands after the accept edge; the captured command must not care.
    a           = W'($urandom);
    b           = W'($urandom);
    polyn_red   = (W+1)'($urandom);
    polyn_grade = MW'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", out_valid, 1'b1);
    o  = out;
    mo = mult_out;
    e  = err;
    if (!hold) handshake();
  endtask

  // ---------------------------------------------------------------- test
  vec_t           vecs[10];
  int             lat;
  logic [W-1:0]   o;
  logic [2*W-1:0] mo;
  logic           e;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    op          = '0;
    polyn_grade = '0;
    polyn_red   = '0;
    a           = '0;
    b           = '0;

    vecs[0] = '{2'b01, 8, 9'h11B, 8'h57, 8'h83, 8'hC1, 16'h2B79, 1'b0, 9};
    vecs[1] = '{2'b10, 8, 9'h11B, 8'h53, 8'hFF, 8'hB5, 16'h1105, 1'b0, 9};
    vecs[2] = '{2'b11, 8, 9'h11B, 8'hFF, 8'hFF, 8'h01, 16'hFE01, 1'b0, 5};
    vecs[3] = '{2'b00, 8, 9'h11B, 8'h57, 8'h83, 8'hD4, 16'h0000, 1'b0, 2};
    vecs[4] = '{2'b01, 4, 9'h013, 8'hF2, 8'h08, 8'h03, 16'h0010, 1'b0, 7};
    vecs[5] = '{2'b01, 1, 9'h003, 8'h02, 8'h03, 8'h00, 16'h0000, 1'b1, 1};
    vecs[6] = '{2'b01, 2, 9'h007, 8'h03, 8'h03, 8'h02, 16'h0005, 1'b0, 6};
    vecs[7] = '{2'b10, 9, 9'h11B, 8'h53, 8'h00, 8'h00, 16'h0000, 1'b1, 1};
    vecs[8] = '{2'b11, 0, 9'h000, 8'h12, 8'h34, 8'hA8, 16'h03A8, 1'b0, 5};
    vecs[9] = '{2'b00, 4, 9'h013, 8'h3C, 8'h05, 8'h09, 16'h0000, 1'b0, 2};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 8'h00);
    check("rst_mult_out", mult_out, 16'h0000);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].m, vecs[i].poly, vecs[i].a, vecs[i].b, 1'b0, lat, o, mo, e);
      check($sformatf("vec%0d_out", i), o, vecs[i].e_out);
      check($sformatf("vec%0d_mult", i), mo, vecs[i].e_mult);
      check($sformatf("vec%0d_err", i), e, vecs[i].e_err);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].e_lat);
    end

    // Hold the result for five cycles with a competing command on the input.
    issue(2'b01, 8, 9'h11B, 8'h57, 8'h83, 1'b1, lat, o, mo, e);
    check("hold_first_out", o, 8'hC1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      op          = 2'b00;
      polyn_grade = MW'(8);
      a           = W'($urandom);
      b           = W'($urandom);
      @(posedge clk); #1;
      check($sformatf("hold%0d_out", i), out, 8'hC1);
      check($sformatf("hold%0d_mult", i), mult_out, 16'h2B79);
      check($sformatf("hold%0d_valid", i), out_valid, 1'b1);
      check($sformatf("hold%0d_in_ready", i), in_ready, 1'b0);
    end
    // in_valid and out_ready together in DONE: only the output side completes.
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("dual_out_valid", out_valid, 1'b0);
    check("dual_busy", busy, 1'b0);
    check("dual_in_ready", in_ready, 1'b1);
    check("dual_out_hold", out, 8'hC1);
    check("dual_mult_hold", mult_out, 16'h2B79);

    // Reset in the middle of a multiply aborts it.
    @(negedge clk);
    op          = 2'b01;
    polyn_grade = MW'(8);
    polyn_red   = 9'h11B;
    a           = 8'h57;
    b           = 8'h83;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out", out, 8'h00);
    check("abort_mult", mult_out, 16'h0000);
    check("abort_err", err, 1'b0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        seen = seen | out_valid;
      end
      check("abort_no_result", seen, 1'b0);
    end
    issue(2'b01, 8, 9'h11B, 8'h57, 8'h83, 1'b0, lat, o, mo, e);
    check("post_rst_out", o, 8'hC1);
    check("post_rst_mult", mo, 16'h2B79);
    check("post_rst_lat", lat, 9);

    // Random commands against the model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]     r_op;
      int             r_m;
      logic [W:0]     r_poly;
      logic [W-1:0]   r_a;
      logic [W-1:0]   r_b;
      logic [W-1:0]   x_out;
      logic [2*W-1:0] x_mult;
      logic           x_err;
      int             x_lat;
      r_op = 2'($urandom);
      r_m  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(2, W);
      r_a  = W'($urandom);
      r_b  = W'($urandom);
      r_poly = (W+1)'($urandom);
      if (r_m >= 2 && r_m <= W) begin
        r_poly = r_poly & (W+1)'((1 << r_m) - 1);
        r_poly[r_m] = 1'b1;
      end
      model(r_op, r_m, r_poly, r_a, r_b, x_out, x_mult, x_err, x_lat);
      issue(r_op, r_m, r_poly, r_a, r_b, 1'b0, lat, o, mo, e);
      check($sformatf("rnd%0d_out", i), o, x_out);
      check($sformatf("rnd%0d_mult", i), mo, x_mult);
      check($sformatf("rnd%0d_err", i), e, x_err);
      check($sformatf("rnd%0d_lat", i), lat, x_lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
